// File: rtl/imm_encoder_pkg.sv
// Shared types and sizes for the operand2 immediate encoder.
package imm_encoder_pkg;
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} enc_state_t;
    localparam int ROT_STEPS = 16;
    localparam int IMM8_W    = 8;
    localparam int ROT_W     = 4;
endpackage

// File: rtl/imm_encoder_if.sv
// Request/result handshake bundle between the instruction generator and the encoder.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic        out_found;
    logic        out_inv;
    logic [11:0] out_imm12;

    modport master (output in_valid, in_value, out_ready,
                    input  in_ready, out_valid, out_found, out_inv, out_imm12);
    modport slave  (input  in_valid, in_value, out_ready,
                    output in_ready, out_valid, out_found, out_inv, out_imm12);
endinterface

// File: rtl/imm_encoder_rot_right.sv
// 32-bit circular rotate right by a 5-bit amount; amount 0 passes data through.
module rot_right (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_amt,
    output logic [31:0] o_data
);
    logic [63:0] w_dbl;

    assign w_dbl  = {i_data, i_data} >> i_amt;
    assign o_data = w_dbl[31:0];
endmodule

// File: rtl/imm_encoder.sv
// Iterative ARM operand2 immediate encoder: tries one even rotation per clock,
// optionally also matching the bitwise inverse so MOV can become MVN.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter bit TRY_INVERT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    imm_encoder_if.slave bus
);
    enc_state_t          r_state, w_next;
    logic [ROT_W-1:0]    r_rot;
    logic [31:0]         r_value;
    logic                r_found, r_inv;
    logic [11:0]         r_imm12;

    logic [4:0]          w_amt;
    logic [31:0]         w_t, w_ti;
    logic                w_hit_p, w_hit_i, w_last;

    // rol by 2*rot expressed as ror by (32 - 2*rot) mod 32
    assign w_amt   = 5'(6'd32 - {1'b0, r_rot, 1'b0});
    assign w_hit_p = (w_t[31:IMM8_W] == '0);
    assign w_last  = (r_rot == ROT_W'(ROT_STEPS - 1));

    rot_right u_rot_plain (.i_data(r_value), .i_amt(w_amt), .o_data(w_t));

    generate
        if (TRY_INVERT) begin : g_inv
            rot_right u_rot_inv (.i_data(~r_value), .i_amt(w_amt), .o_data(w_ti));
            assign w_hit_i = (w_ti[31:IMM8_W] == '0);
        end else begin : g_no_inv
            assign w_ti    = '0;
            assign w_hit_i = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = SEARCH;
            SEARCH:  if (w_hit_p || w_hit_i || w_last) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        bus.out_found = r_found;
        bus.out_inv   = r_inv;
        bus.out_imm12 = r_imm12;
    end

    // Plain match is tested first so it wins over inverted at the same rotation
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rot   <= '0;
            r_value <= '0;
            r_found <= 1'b0;
            r_inv   <= 1'b0;
            r_imm12 <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_value <= bus.in_value;
                    r_rot   <= '0;
                end
                SEARCH: begin
                    if (w_hit_p) begin
                        r_found <= 1'b1;
                        r_inv   <= 1'b0;
                        r_imm12 <= {r_rot, w_t[IMM8_W-1:0]};
                    end else if (w_hit_i) begin
                        r_found <= 1'b1;
                        r_inv   <= 1'b1;
                        r_imm12 <= {r_rot, w_ti[IMM8_W-1:0]};
                    end else if (w_last) begin
                        r_found <= 1'b0;
                        r_inv   <= 1'b0;
                        r_imm12 <= '0;
                    end else begin
                        r_rot   <= r_rot + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
